// File: rtl/logic_mux_pipe_if.sv
// logic_mux_pipe_if: operand/result handshake bundle for logic_mux_pipe
interface logic_mux_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [CNT_W-1:0] op_count;
  modport master (
    output in_valid, a, b, op, acc_sel, out_ready,
    input  in_ready, out_valid, result, zero, op_count
  );
  modport slave (
    input  in_valid, a, b, op, acc_sel, out_ready,
    output in_ready, out_valid, result, zero, op_count
  );
endinterface

// File: rtl/logic_mux_pipe.sv
// logic_mux_pipe: two-stage valid/ready bitwise function unit with accumulator feedback
module logic_mux_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  logic_mux_pipe_if.slave bus
);
  logic             s1_valid, s1_acc, s1_adv, out_valid, zero;
  logic [WIDTH-1:0] s1_a, s1_b, acc, opa, f, result;
  logic [2:0]       s1_op;
  logic [CNT_W-1:0] op_count;
  assign s1_adv       = s1_valid && (!out_valid || bus.out_ready);
  assign bus.in_ready = !s1_valid || s1_adv;
  assign bus.out_valid = out_valid;
  assign bus.result   = result;
  assign bus.zero     = zero;
  assign bus.op_count = op_count;
  always_comb begin
    opa = s1_acc ? acc : s1_a;
    case (s1_op)
      3'b000:  f = opa & s1_b;
      3'b001:  f = opa | s1_b;
      3'b010:  f = ~(opa & s1_b);
      3'b011:  f = ~(opa | s1_b);
      3'b100:  f = opa ^ s1_b;
      3'b101:  f = ~(opa ^ s1_b);
      3'b110:  f = ~opa;
      default: f = s1_b;
    endcase
  end
  always_ff @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) begin
      s1_a   <= bus.a;
      s1_b   <= bus.b;
      s1_op  <= bus.op;
      s1_acc <= bus.acc_sel;
    end
  end
  // acc tracks f at every stage-1 to stage-2 transfer so acc_sel ops chain back-to-back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      acc       <= '0;
      op_count  <= '0;
    end else begin
      if (bus.in_valid && bus.in_ready) s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
      if (s1_adv) begin
        result    <= f;
        zero      <= (f == '0);
        acc       <= f;
        out_valid <= 1'b1;
      end else if (out_valid && bus.out_ready) out_valid <= 1'b0;
      if (out_valid && bus.out_ready) op_count <= op_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_logic_mux_pipe.sv
// tb_logic_mux_pipe: directed and random checks against a queue-based reference model
module tb_logic_mux_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic_mux_pipe_if #(.WIDTH(8), .CNT_W(8)) bus ();
  logic_mux_pipe_if #(.WIDTH(8), .CNT_W(2)) bus2 ();
  logic_mux_pipe #(.WIDTH(8), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic_mux_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  int checks = 0;
  int errors = 0;
  int n_acc = 0;
  logic [7:0] q[$];
  logic [7:0] got[$];
  logic [7:0] macc = '0;
  logic [7:0] mcnt = '0;
  function automatic logic [7:0] fn(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return ~(x & y);
      3'd3: return ~(x | y);
      3'd4: return x ^ y;
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return y;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    logic acc_now, hs;
    #1;
    acc_now = bus.in_valid && bus.in_ready && rst_n;
    hs = bus.out_valid && bus.out_ready && rst_n;
    chk("op_count", 32'(bus.op_count), 32'(mcnt));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2 || bus.out_ready));
    if (hs) begin
      if (q.size() == 0) chk("spurious_out", 32'(bus.out_valid), 0);
      else begin
        chk("result", 32'(bus.result), 32'(q[0]));
        chk("zero", 32'(bus.zero), 32'(q[0] == 8'h00));
        got.push_back(bus.result);
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      macc = '0;
      mcnt = '0;
    end else begin
      if (hs) begin
        if (q.size() != 0) void'(q.pop_front());
        mcnt++;
      end
      if (acc_now) begin
        macc = fn(bus.op, bus.acc_sel ? macc : bus.a, bus.b);
        q.push_back(macc);
        n_acc++;
      end
    end
    @(negedge clk);
  endtask
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic s);
    bus.in_valid = v; bus.a = a; bus.b = b; bus.op = op; bus.acc_sel = s;
  endtask
  initial begin
    logic [7:0] t1 [8] = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'h3C};
    logic [7:0] t3 [3] = '{8'h0F, 8'hF0, 8'h0F};
    logic [7:0] v4 [3] = '{8'h11, 8'h22, 8'h33};
    logic [1:0] t6 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int base, n;
    logic hs2;
    drive(0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    bus2.in_valid = 0; bus2.a = 0; bus2.b = 0; bus2.op = 0; bus2.acc_sel = 0; bus2.out_ready = 0;
    @(negedge clk);
    cycle(); cycle();
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_zero", 32'(bus.zero), 1);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_op_count", 32'(bus.op_count), 0);
    // all eight functions back to back
    got.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'hF0, 8'h3C, 3'(i), 0);
      cycle();
      if (i == 0) chk("latency_edge1", 32'(bus.out_valid), 0);
      if (i == 1) chk("latency_edge2", 32'(bus.out_valid), 1);
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("t1_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk($sformatf("t1_res%0d", i), 32'(got[i]), 32'(t1[i]));
    chk("t1_op_count", 32'(bus.op_count), 8);
    // zero flag
    drive(1, 8'hAA, 8'h55, 3'd0, 0); cycle();
    drive(1, 8'hAA, 8'h55, 3'd1, 0); cycle();
    drive(0, 0, 0, 0, 0); cycle();
    chk("t2_ff", 32'(bus.result), 32'hFF);
    chk("t2_ff_zero", 32'(bus.zero), 0);
    cycle();
    // accumulator chaining
    got.delete();
    drive(1, 8'h00, 8'h0F, 3'd7, 0); cycle();
    drive(1, 8'h00, 8'hFF, 3'd4, 1); cycle();
    drive(1, 8'h00, 8'hFF, 3'd4, 1); cycle();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("t3_count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk($sformatf("t3_res%0d", i), 32'(got[i]), 32'(t3[i]));
    // backpressure
    got.delete();
    bus.out_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 4; i++) begin
      drive(1, v4[(n_acc - base) < 3 ? (n_acc - base) : 2], 8'h5A, 3'd4, 0);
      cycle();
    end
    chk("t4_accepted", n_acc - base, 2);
    chk("t4_in_ready", 32'(bus.in_ready), 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 8'h33, 8'h5A, 3'd4, 0);
      cycle();
      chk("t4_hold", 32'(bus.result), 32'(8'h11 ^ 8'h5A));
      chk("t4_hold_valid", 32'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8 && (n_acc - base) < 3; i++) cycle();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle();
    chk("t4_count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk($sformatf("t4_res%0d", i), 32'(got[i]), 32'(v4[i] ^ 8'h5A));
    // reset with both stages full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(1, 8'h77, 8'h0F, 3'd1, 0); cycle(); end
    chk("t5_full", 32'(bus.in_ready), 0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    #1;
    chk("t5_out_valid", 32'(bus.out_valid), 0);
    chk("t5_result", 32'(bus.result), 0);
    chk("t5_zero", 32'(bus.zero), 1);
    chk("t5_op_count", 32'(bus.op_count), 0);
    chk("t5_in_ready", 32'(bus.in_ready), 1);
    got.delete();
    drive(1, 8'hEE, 8'h00, 3'd4, 1); cycle();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_acc_cnt", got.size(), 1);
    if (got.size() > 0) chk("t5_acc", 32'(got[0]), 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 3'($urandom), $urandom_range(0, 2) == 0);
      bus.out_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    drive(0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("rand_drained", q.size(), 0);
    chk("rand_out_valid", 32'(bus.out_valid), 0);
    // small counter wrap
    bus2.in_valid = 1'b1;
    bus2.out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 5; i++) begin
      #1;
      hs2 = bus2.out_valid && bus2.out_ready;
      @(posedge clk);
      @(negedge clk);
      if (hs2) begin
        chk($sformatf("t6_cnt%0d", n), 32'(bus2.op_count), 32'(t6[n]));
        n++;
      end
    end
    chk("t6_handshakes", n, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
